// File: rtl/reorder_buffer.sv
// In-order-retirement reorder buffer: dispatch allocates tail entries, the CDB marks them done, commit retires up to COMMIT_WIDTH per cycle.
// Latency: entry visible the cycle after dispatch; commit the cycle after CDB write (dispatch-to-commit minimum 2 cycles).
// Backpressure: dispatch_ready = !full, no credit from same-cycle commits; `define ROB_PRECISE_EXC_EN enables precise-exception flush.
module reorder_buffer #(
    parameter int ROB_SIZE          = 16,
    parameter int COMMIT_WIDTH      = 2,
    parameter int XLEN              = 32,
    parameter int ARCH_REG_ADDR_LEN = 5,
    localparam int TAG_W            = $clog2(ROB_SIZE)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  dispatch_valid,
    output logic                                  dispatch_ready,
    input  logic [ARCH_REG_ADDR_LEN-1:0]          dispatch_dest,
    input  logic                                  dispatch_wr_en,
    input  logic [XLEN-1:0]                       dispatch_pc,
    output logic [TAG_W-1:0]                      dispatch_tag,
    input  logic                                  cdb_valid,
    input  logic [TAG_W-1:0]                      cdb_tag,
    input  logic [XLEN-1:0]                       cdb_result,
    input  logic                                  cdb_exception,
    input  logic                                  flush,
    output logic [COMMIT_WIDTH-1:0]               commit_valid,
    output logic [COMMIT_WIDTH-1:0]               commit_wr_en,
    output logic [COMMIT_WIDTH*ARCH_REG_ADDR_LEN-1:0] commit_arch_reg,
    output logic [COMMIT_WIDTH*XLEN-1:0]          commit_data,
    output logic [TAG_W:0]                        count,
    output logic                                  empty,
    output logic                                  full,
    output logic                                  exc_flush,
    output logic [XLEN-1:0]                       exc_pc
);

    // Per-entry state
    logic [ROB_SIZE-1:0]          valid_q;
    logic [ROB_SIZE-1:0]          ready_q;
    logic [ROB_SIZE-1:0]          wr_en_q;
    logic [ARCH_REG_ADDR_LEN-1:0] dest_q   [ROB_SIZE];
    logic [XLEN-1:0]              result_q [ROB_SIZE];
`ifdef ROB_PRECISE_EXC_EN
    logic [ROB_SIZE-1:0]          exc_q;
    logic [XLEN-1:0]              pc_q     [ROB_SIZE];
`endif

    logic [TAG_W-1:0] head_q, tail_q;
    logic [TAG_W:0]   count_q;

    logic             fire;
    logic             clear_all;
    logic             chain;
    logic [TAG_W-1:0] lane_idx;
    logic [TAG_W:0]   n_commit;
    logic [TAG_W-1:0] head_d;
    logic [TAG_W:0]   count_d;

    assign full           = (count_q == (TAG_W+1)'(ROB_SIZE));
    assign empty          = (count_q == '0);
    assign count          = count_q;
    assign dispatch_ready = !full;
    assign dispatch_tag   = tail_q;
    assign fire           = dispatch_valid && dispatch_ready && !flush;

`ifdef ROB_PRECISE_EXC_EN
    // Completed excepting instruction at head: request a precise flush this cycle.
    assign exc_flush = valid_q[head_q] & ready_q[head_q] & exc_q[head_q];
    assign exc_pc    = exc_flush ? pc_q[head_q] : '0;
`else
    // Exception reporting absent: PC and exception flag are not kept.
    logic unused_exc_inputs;
    assign unused_exc_inputs = ^{cdb_exception, dispatch_pc};
    assign exc_flush = 1'b0;
    assign exc_pc    = '0;
`endif

    assign clear_all = flush | exc_flush;
    assign head_d    = head_q + n_commit[TAG_W-1:0];
    assign count_d   = count_q + {{TAG_W{1'b0}}, fire} - n_commit;

    // Prefix-contiguous commit lanes starting at head; a non-eligible entry stops all later lanes.
    always_comb begin
        commit_valid    = '0;
        commit_wr_en    = '0;
        commit_arch_reg = '0;
        commit_data     = '0;
        n_commit        = '0;
        lane_idx        = head_q;
        chain           = !flush;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            lane_idx = head_q + TAG_W'(i);
`ifdef ROB_PRECISE_EXC_EN
            chain = chain & valid_q[lane_idx] & ready_q[lane_idx] & ~exc_q[lane_idx];
`else
            chain = chain & valid_q[lane_idx] & ready_q[lane_idx];
`endif
            commit_valid[i] = chain;
            if (chain) begin
                commit_wr_en[i] = wr_en_q[lane_idx];
                commit_arch_reg[i*ARCH_REG_ADDR_LEN +: ARCH_REG_ADDR_LEN] = dest_q[lane_idx];
                commit_data[i*XLEN +: XLEN] = result_q[lane_idx];
                n_commit = n_commit + (TAG_W+1)'(1);
            end
        end
    end

    // Pointer, count and entry updates: flush wins, otherwise CDB write, retire, then allocate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            ready_q <= '0;
            wr_en_q <= '0;
`ifdef ROB_PRECISE_EXC_EN
            exc_q   <= '0;
`endif
            for (int i = 0; i < ROB_SIZE; i++) begin
                dest_q[i]   <= '0;
                result_q[i] <= '0;
`ifdef ROB_PRECISE_EXC_EN
                pc_q[i]     <= '0;
`endif
            end
        end else if (clear_all) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (cdb_valid && valid_q[cdb_tag]) begin
                ready_q[cdb_tag]  <= 1'b1;
                result_q[cdb_tag] <= cdb_result;
`ifdef ROB_PRECISE_EXC_EN
                exc_q[cdb_tag]    <= cdb_exception;
`endif
            end
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (commit_valid[i]) begin
                    valid_q[head_q + TAG_W'(i)] <= 1'b0;
                end
            end
            // The tail entry is never valid when fire is set, so it cannot collide with a retire or CDB write.
            if (fire) begin
                valid_q[tail_q] <= 1'b1;
                ready_q[tail_q] <= 1'b0;
                wr_en_q[tail_q] <= dispatch_wr_en;
                dest_q[tail_q]  <= dispatch_dest;
`ifdef ROB_PRECISE_EXC_EN
                exc_q[tail_q]   <= 1'b0;
                pc_q[tail_q]    <= dispatch_pc;
`endif
                tail_q <= tail_q + TAG_W'(1);
            end
            head_q  <= head_d;
            count_q <= count_d;
        end
    end

endmodule
